// File: rtl/sig_pkg.sv
// Shared constants and helpers for the microphone front-end.
// Imported by the decimator and its clip detector.
package sig_pkg;

    localparam int WIDTH_DEF = 8;

    localparam int CLIP_LO = 0;
    localparam logic [WIDTH_DEF-1:0] CLIP_HI = '1;

    function automatic int phase_w(input int dec_log2);
        return (dec_log2 < 1) ? 1 : dec_log2;
    endfunction

endpackage

// File: rtl/clip_detector.sv
// Clip indicator: held for HOLD output strobes after the last
// rail-valued input sample.
module clip_detector
    import sig_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_accept,
    input  logic [WIDTH-1:0] sample,
    input  logic             out_strobe,
    output logic             clip_flag
);

    logic [7:0] cnt_q, cnt_d;
    logic       flag_q;
    logic       is_clip;

    // Either rail counts; all-ones is width-independent via reduction.
    assign is_clip = (sample == WIDTH'(CLIP_LO)) || (&sample);

    always_comb begin
        cnt_d = cnt_q;
        if (sample_accept && is_clip) begin
            cnt_d = 8'(HOLD);
        end else if (out_strobe && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 8'd0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= (cnt_d != 8'd0);
        end
    end

    assign clip_flag = flag_q;

endmodule

// File: rtl/mic_decimator.sv
// Block-averaging decimator for raw microphone ADC samples,
// feeding the signal-delay stage with one strobe per block.
module mic_decimator
    import sig_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int DEC_LOG2 = 2,
    parameter int HOLD     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         adc_valid,
    input  logic [WIDTH-1:0]             adc_data,
    output logic [WIDTH-1:0]             sample_out,
    output logic                         sample_valid,
    output logic                         clip_flag,
    output logic [phase_w(DEC_LOG2)-1:0] block_phase
);

    localparam int PW = phase_w(DEC_LOG2);
    localparam int AW = WIDTH + DEC_LOG2;
    localparam logic [PW-1:0] LAST = PW'((1 << DEC_LOG2) - 1);

    logic [AW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic [AW-1:0]    sum;
    logic             accept;

    assign accept = adc_valid && !clear;
    assign sum    = acc_q + AW'(adc_data);

    always_comb begin
        acc_d   = acc_q;
        phase_d = phase_q;
        out_d   = out_q;
        valid_d = 1'b0;
        if (clear) begin
            acc_d   = '0;
            phase_d = '0;
        end else if (adc_valid) begin
            if (phase_q == LAST) begin
                // Truncating divide by the block length.
                out_d   = sum[AW-1:DEC_LOG2];
                valid_d = 1'b1;
                acc_d   = '0;
                phase_d = '0;
            end else begin
                acc_d   = sum;
                phase_d = phase_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q   <= '0;
            phase_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    clip_detector #(
        .WIDTH (WIDTH),
        .HOLD  (HOLD)
    ) u_clip (
        .clk           (clk),
        .rst           (rst),
        .sample_accept (accept),
        .sample        (adc_data),
        .out_strobe    (valid_q),
        .clip_flag     (clip_flag)
    );

    assign sample_out   = out_q;
    assign sample_valid = valid_q;
    assign block_phase  = phase_q;

endmodule

// File: tb/tb_mic_decimator.sv
// Directed bench for mic_decimator: a vector table plus
// hand-written reset, gap, clip-hold and pass-through sequences.
module tb_mic_decimator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       adc_valid = 1'b0;
    logic [7:0] adc_data = 8'd0;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic       clip_flag;
    logic [1:0] block_phase;

    logic       clear0 = 1'b0;
    logic       v0 = 1'b0;
    logic [7:0] d0 = 8'd0;
    logic [7:0] out0;
    logic       sv0;
    logic       clip0;
    logic [0:0] ph0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mic_decimator #(.WIDTH(8), .DEC_LOG2(2), .HOLD(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .adc_valid    (adc_valid),
        .adc_data     (adc_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .clip_flag    (clip_flag),
        .block_phase  (block_phase)
    );

    mic_decimator #(.WIDTH(8), .DEC_LOG2(0), .HOLD(4)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear0),
        .adc_valid    (v0),
        .adc_data     (d0),
        .sample_out   (out0),
        .sample_valid (sv0),
        .clip_flag    (clip0),
        .block_phase  (ph0)
    );

    typedef struct {
        logic       v;
        logic       c;
        logic [7:0] d;
        logic [7:0] eo;
        logic       ev;
        logic       ec;
        logic [1:0] ep;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(logic v, logic c, logic [7:0] d,
                                logic [7:0] eo, logic ev, logic ec,
                                logic [1:0] ep);
        vec_t r;
        r.v = v; r.c = c; r.d = d;
        r.eo = eo; r.ev = ev; r.ec = ec; r.ep = ep;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic c, input logic [7:0] d);
        @(negedge clk);
        adc_valid = v;
        clear     = c;
        adc_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eo,
                           input logic ev, input logic ec,
                           input logic [1:0] ep);
        chk({tag, ".out"},   32'(sample_out),   32'(eo));
        chk({tag, ".valid"}, 32'(sample_valid), 32'(ev));
        chk({tag, ".clip"},  32'(clip_flag),    32'(ec));
        chk({tag, ".phase"}, 32'(block_phase),  32'(ep));
    endtask

    task automatic do_reset();
        @(negedge clk);
        adc_valid = 1'b0;
        clear     = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 10,  0,   0, 0, 1);
        tbl[1]  = mk(1, 0, 20,  0,   0, 0, 2);
        tbl[2]  = mk(1, 0, 30,  0,   0, 0, 3);
        tbl[3]  = mk(1, 0, 41,  25,  1, 0, 0);
        tbl[4]  = mk(0, 0, 0,   25,  0, 0, 0);
        tbl[5]  = mk(0, 0, 0,   25,  0, 0, 0);
        tbl[6]  = mk(1, 1, 255, 25,  0, 0, 0);
        tbl[7]  = mk(1, 0, 200, 25,  0, 0, 1);
        tbl[8]  = mk(1, 0, 200, 25,  0, 0, 2);
        tbl[9]  = mk(1, 1, 7,   25,  0, 0, 0);
        tbl[10] = mk(1, 0, 100, 25,  0, 0, 1);
        tbl[11] = mk(1, 0, 100, 25,  0, 0, 2);
        tbl[12] = mk(1, 0, 100, 25,  0, 0, 3);
        tbl[13] = mk(1, 0, 100, 100, 1, 0, 0);
        tbl[14] = mk(0, 1, 0,   100, 0, 0, 0);
        tbl[15] = mk(1, 0, 0,   100, 0, 1, 1);
        tbl[16] = mk(1, 0, 4,   100, 0, 1, 2);
        tbl[17] = mk(1, 0, 4,   100, 0, 1, 3);
        tbl[18] = mk(1, 0, 5,   3,   1, 1, 0);
        tbl[19] = mk(0, 0, 0,   3,   0, 1, 0);

        // Reset held with adc_valid toggling.
        adc_data = 8'd255;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            adc_valid = (i % 2 == 0);
            @(posedge clk);
            #1;
            chk_all($sformatf("rst%0d", i), 8'd0, 1'b0, 1'b0, 2'd0);
        end
        @(negedge clk);
        adc_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all("rel", 8'd0, 1'b0, 1'b0, 2'd0);

        // Table-driven vectors.
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].v, tbl[i].c, tbl[i].d);
            chk_all($sformatf("vec%0d", i), tbl[i].eo, tbl[i].ev,
                    tbl[i].ec, tbl[i].ep);
        end

        // Gapped input: 10,20,30,41 with 3,0,5 idle cycles.
        do_reset();
        begin
            logic [7:0] gd[4];
            int         gap[4];
            gd[0] = 10; gd[1] = 20; gd[2] = 30; gd[3] = 41;
            gap[0] = 3; gap[1] = 0; gap[2] = 5; gap[3] = 0;
            for (int i = 0; i < 4; i++) begin
                step(1'b1, 1'b0, gd[i]);
                if (i < 3) chk("gap.nov", 32'(sample_valid), 32'd0);
                for (int g = 0; g < gap[i]; g++) begin
                    step(1'b0, 1'b0, 8'd0);
                    chk("gap.idle", 32'(sample_valid), 32'd0);
                end
            end
            chk("gap.out", 32'(sample_out), 32'd25);
            chk("gap.valid", 32'(sample_valid), 32'd1);
            step(1'b0, 1'b0, 8'd0);
            chk("gap.pulse", 32'(sample_valid), 32'd0);
            chk("gap.hold", 32'(sample_out), 32'd25);
        end

        // Clip and hold: 4 x 255 then 16 x 100.
        do_reset();
        step(1'b1, 1'b0, 8'd255);
        chk("clip.rise", 32'(clip_flag), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd255);
        chk("clip.out255", 32'(sample_out), 32'd255);
        chk("clip.v255", 32'(sample_valid), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b0, 8'd100);
            chk($sformatf("clip.flag%0d", k), 32'(clip_flag),
                32'(k < 13));
            if (k % 4 == 0) begin
                chk($sformatf("clip.out%0d", k), 32'(sample_out), 32'd100);
                chk($sformatf("clip.v%0d", k), 32'(sample_valid), 32'd1);
            end
        end

        // Mid-block async reset, then a fresh block.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd50);
        chk("mid.phase", 32'(block_phase), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk_all("mid.rst", 8'd0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        adc_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd8);
        chk("mid.nov", 32'(sample_valid), 32'd0);
        step(1'b1, 1'b0, 8'd8);
        chk_all("mid.blk", 8'd8, 1'b1, 1'b0, 2'd0);
        step(1'b0, 1'b0, 8'd0);

        // Pass-through instance.
        @(negedge clk);
        v0 = 1'b1;
        d0 = 8'd5;
        @(posedge clk);
        #1;
        chk("pt.out5", 32'(out0), 32'd5);
        chk("pt.v5", 32'(sv0), 32'd1);
        @(negedge clk);
        d0 = 8'd9;
        @(posedge clk);
        #1;
        chk("pt.out9", 32'(out0), 32'd9);
        chk("pt.v9", 32'(sv0), 32'd1);
        @(negedge clk);
        v0 = 1'b0;
        @(posedge clk);
        #1;
        chk("pt.idle", 32'(sv0), 32'd0);
        chk("pt.hold", 32'(out0), 32'd9);
        chk("pt.phase", 32'(ph0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
